// File: rtl/calc_fetch.sv
// Instruction fetch stage: owns the PC, issues reads to instMem, buffers responses in a small FIFO for decode.
// Optional per-stage statistics counters are built when FETCH_STATS_EN is defined.
module calc_fetch #(
    parameter int          INSTR_W    = 32,
    parameter int          IMEM_AW    = 10,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               halt,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [31:0]        instr_pc,
    output logic [15:0]        fetch_count,
    output logic [15:0]        flush_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam int CNT_W = PTR_W + 2;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0] FULL_C  = OCC_W'(FIFO_DEPTH);

    logic [31:0]        r_pc;
    logic               r_epoch;
    logic               r_vld_p1;
    logic [31:0]        r_pc_p1;
    logic               r_epoch_p1;
    logic [INSTR_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [31:0]        r_fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [OCC_W-1:0]   r_occ;

    logic               w_pop;
    logic               w_push;
    logic               w_issue;
    logic [CNT_W-1:0]   w_claimed;
    logic [31:0]        w_redir_pc;

    // A slot is claimed by every buffered word and every in-flight read; a pop frees one this cycle.
    assign w_pop      = instr_valid && instr_ready;
    assign w_claimed  = CNT_W'(r_occ) + CNT_W'(r_vld_p1) - CNT_W'(w_pop);
    assign w_issue    = reset && !halt && !redirect_valid && (w_claimed < DEPTH_C);
    assign w_push     = r_vld_p1 && (r_epoch_p1 == r_epoch) && !redirect_valid;
    assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;

    assign imem_en   = w_issue;
    assign imem_addr = r_pc[IMEM_AW+1:2];

    // Stage p0: PC, epoch and FIFO bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc     <= RESET_PC;
            r_epoch  <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            r_vld_p1 <= w_issue;
            if (redirect_valid) begin
                r_pc     <= w_redir_pc;
                r_epoch  <= ~r_epoch;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_occ    <= '0;
            end else begin
                if (w_issue) r_pc <= r_pc + 32'd4;
                if (w_push)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_occ <= r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
            end
        end
    end

    // Stage p1: tag of the outstanding read, response capture into the FIFO
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_pc_p1    <= r_pc;
            r_epoch_p1 <= r_epoch;
        end
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= imem_rdata;
            r_fifo_pc[r_wr_ptr]   <= r_pc_p1;
        end
    end

    assign instr_valid = (r_occ != '0);
    assign instr_data  = instr_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign instr_pc    = instr_valid ? r_fifo_pc[r_rd_ptr]   : '0;

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        (w_push && !w_pop) |-> (r_occ != FULL_C));

`ifdef FETCH_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] r_fetch_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_push)         r_fetch_cnt <= sat_inc(r_fetch_cnt);
            if (redirect_valid) r_flush_cnt <= sat_inc(r_flush_cnt);
        end
    end

    assign fetch_count = r_fetch_cnt;
    assign flush_count = r_flush_cnt;
`else
    assign fetch_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_calc_fetch.sv
// Self-checking bench for calc_fetch: directed table and corner sequences plus randomized traffic
// scored against a slot-counting reference model of the fetch stream.
module tb_calc_fetch;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC_W = 32'hFFFF_FFF8;
`ifdef FETCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        halt, redirect_valid, instr_ready;
    logic [31:0] redirect_pc;
    logic        imem_en, instr_valid;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata, instr_data, instr_pc;
    logic [15:0] fetch_count, flush_count;

    logic        halt_w, redirect_valid_w, instr_ready_w;
    logic [31:0] redirect_pc_w;
    logic        imem_en_w, instr_valid_w;
    logic [9:0]  imem_addr_w;
    logic [31:0] imem_rdata_w, instr_data_w, instr_pc_w;
    logic [15:0] fetch_count_w, flush_count_w;

    int checks = 0;
    int errors = 0;

    calc_fetch #(.INSTR_W(32), .IMEM_AW(10), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .halt(halt), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc), .fetch_count(fetch_count),
        .flush_count(flush_count));

    calc_fetch #(.INSTR_W(32), .IMEM_AW(10), .RESET_PC(RPC_W), .FIFO_DEPTH(DEPTH)) dut_w (
        .clk(clk), .reset(reset), .imem_en(imem_en_w), .imem_addr(imem_addr_w),
        .imem_rdata(imem_rdata_w), .halt(halt_w), .redirect_valid(redirect_valid_w),
        .redirect_pc(redirect_pc_w), .instr_valid(instr_valid_w), .instr_ready(instr_ready_w),
        .instr_data(instr_data_w), .instr_pc(instr_pc_w), .fetch_count(fetch_count_w),
        .flush_count(flush_count_w));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instMem contents: word k holds 0xA000_0000 + k
    always_ff @(posedge clk) begin
        if (imem_en)   imem_rdata   <= 32'hA000_0000 + {22'b0, imem_addr};
        if (imem_en_w) imem_rdata_w <= 32'hA000_0000 + {22'b0, imem_addr_w};
    end

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return 32'hA000_0000 + {22'b0, pc[11:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: slots = words issued since the last flush and not yet consumed.
    int          m_cnt;
    bit          m_en_prev;
    logic [31:0] m_iss_pc, m_exp_pc;
    logic [15:0] m_fetch, m_flush;

    always @(negedge clk) begin
        bit pop, exp_en, exp_valid;
        #2;
        if (!reset) begin
            chk("mdl_rst_valid", instr_valid, 0);
            chk("mdl_rst_en", imem_en, 0);
            chk("mdl_rst_outs", instr_pc | instr_data, 0);
            chk("mdl_rst_cnts", {fetch_count, flush_count}, 0);
            m_cnt = 0; m_en_prev = 0;
            m_iss_pc = 32'h0; m_exp_pc = 32'h0;
            m_fetch = 0; m_flush = 0;
        end else begin
            pop       = instr_valid && instr_ready;
            exp_en    = !halt && !redirect_valid && ((m_cnt - (pop ? 1 : 0)) < DEPTH);
            exp_valid = (m_cnt - (m_en_prev ? 1 : 0)) > 0;
            chk("mdl_en", imem_en, exp_en);
            if (imem_en) chk("mdl_addr", imem_addr, m_iss_pc[11:2]);
            chk("mdl_valid", instr_valid, exp_valid);
            if (instr_valid) begin
                chk("mdl_pc", instr_pc, m_exp_pc);
                chk("mdl_data", instr_data, word_at(m_exp_pc));
            end
            chk("mdl_fetch_cnt", fetch_count, STATS ? m_fetch : 16'h0);
            chk("mdl_flush_cnt", flush_count, STATS ? m_flush : 16'h0);
            if (pop) m_exp_pc = m_exp_pc + 32'd4;
            if (m_en_prev && !redirect_valid && m_fetch != 16'hFFFF) m_fetch = m_fetch + 16'd1;
            if (redirect_valid) begin
                if (m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
                m_cnt = 0; m_en_prev = 0;
                m_iss_pc = redirect_pc & 32'hFFFF_FFFC;
                m_exp_pc = m_iss_pc;
            end else begin
                m_cnt = m_cnt - (pop ? 1 : 0) + (exp_en ? 1 : 0);
                m_en_prev = exp_en;
                if (exp_en) m_iss_pc = m_iss_pc + 32'd4;
            end
        end
    end

    typedef struct {
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_en;
        logic [9:0]  exp_addr;
        logic [31:0] exp_pc_w;
    } vec_t;

    vec_t tbl [6];
    int   n, en_cnt, pops;

    initial begin
        reset = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
        halt_w = 1'b0; redirect_valid_w = 1'b0; redirect_pc_w = '0; instr_ready_w = 1'b1;
        tbl[0] = '{1'b1, 1'b0, 32'h0, 1'b1, 10'd0, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 32'h0, 1'b1, 10'd1, 32'h0};
        tbl[2] = '{1'b1, 1'b1, 32'h0, 1'b1, 10'd2, 32'hFFFF_FFF8};
        tbl[3] = '{1'b1, 1'b1, 32'h4, 1'b1, 10'd3, 32'hFFFF_FFFC};
        tbl[4] = '{1'b1, 1'b1, 32'h8, 1'b1, 10'd4, 32'h0000_0000};
        tbl[5] = '{1'b1, 1'b1, 32'hC, 1'b1, 10'd5, 32'h0000_0004};

        @(negedge clk); @(negedge clk);
        #1;
        chk("rst_valid", instr_valid, 0);
        chk("rst_en", imem_en, 0);
        chk("rst_w_cnts", {fetch_count_w, flush_count_w}, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            instr_ready = tbl[i].ready;
            #1;
            chk("tbl_valid", instr_valid, tbl[i].exp_valid);
            chk("tbl_en", imem_en, tbl[i].exp_en);
            chk("tbl_addr", imem_addr, tbl[i].exp_addr);
            chk("tbl_w_valid", instr_valid_w, tbl[i].exp_valid);
            if (tbl[i].exp_valid) begin
                chk("tbl_pc", instr_pc, tbl[i].exp_pc);
                chk("tbl_data", instr_data, word_at(tbl[i].exp_pc));
                chk("tbl_w_pc", instr_pc_w, tbl[i].exp_pc_w);
                chk("tbl_w_data", instr_data_w, word_at(tbl[i].exp_pc_w));
            end
            @(negedge clk);
        end

        en_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            instr_ready = 1'b0;
            #1;
            chk("stall_valid", instr_valid, 1);
            chk("stall_pc", instr_pc, 32'h10);
            if (imem_en) en_cnt++;
            @(negedge clk);
        end
        chk("stall_en", en_cnt, 0);
        instr_ready = 1'b1;
        repeat (6) @(negedge clk);

        redirect_valid = 1'b1; redirect_pc = 32'h43;
        #1;
        chk("redir_en", imem_en, 0);
        @(negedge clk);
        redirect_valid = 1'b0; redirect_pc = '0;
        #1;
        chk("redir_flush_valid", instr_valid, 0);
        n = 1;
        while (!instr_valid && n < 10) begin
            @(negedge clk); #1; n++;
        end
        chk("redir_lat", n, 3);
        chk("redir_pc", instr_pc, 32'h40);
        chk("redir_data", instr_data, 32'hA000_0010);
        chk("redir_flush_cnt", flush_count, STATS ? 32'd1 : 32'd0);
        repeat (5) @(negedge clk);

        en_cnt = 0; pops = 0;
        for (int i = 0; i < 4; i++) begin
            halt = 1'b1;
            #1;
            if (imem_en) en_cnt++;
            if (instr_valid) pops++;
            @(negedge clk);
        end
        halt = 1'b0;
        chk("halt_en", en_cnt, 0);
        chk("halt_drain", pops, 2);
        repeat (4) @(negedge clk);

        for (int i = 0; i < 400; i++) begin
            instr_ready    = ($urandom_range(0, 9) < 7);
            halt           = ($urandom_range(0, 9) == 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            @(negedge clk);
        end
        halt = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("pre_rst_valid", instr_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_async_valid", instr_valid, 0);
        chk("rst_async_en", imem_en, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1; instr_ready = 1'b1;
        #1;
        chk("rst_fetch_cnt", fetch_count, 0);
        n = 0;
        while (!instr_valid && n < 10) begin
            @(negedge clk); #1; n++;
        end
        chk("rst_lat", n, 2);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_data", instr_data, 32'hA000_0000);
        repeat (6) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
